// File: rtl/core_result_arbiter.sv
// core_result_arbiter: shares one result stream among CORES halted cores in round-robin order.
// Define MSPU_ARB_TIMEOUT_EN to add a per-packet watchdog and the sticky timeout_err output.
module core_result_arbiter #(
  parameter int unsigned CORES   = 4,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CORES-1:0]          core_halt,
  output logic [CORES-1:0]          core_src_req,
  input  logic [CORES-1:0]          core_src_sop,
  input  logic [CORES-1:0]          core_src_eop,
  input  logic [CORES-1:0]          core_src_valid,
  input  logic [CORES*DATA_W-1:0]   core_src_q,
  output logic [DATA_W-1:0]         src_data,
  output logic                      src_valid,
  output logic                      src_sop,
  output logic                      src_eop,
  input  logic                      src_ready,
  output logic                      core_release,
  output logic [$clog2(CORES)-1:0]  released_core_id,
  output logic                      busy,
  output logic [31:0]               packets_sent
`ifdef MSPU_ARB_TIMEOUT_EN
  ,
  output logic                      timeout_err
`endif
);

  localparam int unsigned IDW = $clog2(CORES);

  if (CORES < 2 || CORES > 16 || (CORES & (CORES - 1)) != 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("core_result_arbiter: CORES must be a power of two in 2..16 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {IDLE, REQ, STREAM, RELEASE} state_t;

  state_t             state_q, state_d;
  logic [CORES-1:0]   halt_d_q, halt_d_d;
  logic [CORES-1:0]   pending_q, pending_d;
  logic [CORES-1:0]   pending_set, pending_clr;
  logic [IDW-1:0]     grant_q, grant_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic [CORES-1:0]   req_q, req_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic               release_q, release_d;
  logic [IDW-1:0]     rel_id_q, rel_id_d;
  logic               busy_q, busy_d;
  logic [31:0]        packets_q, packets_d;
  logic               pkt_done;
`ifdef MSPU_ARB_TIMEOUT_EN
  logic [31:0]        cnt_q, cnt_d;
  logic               terr_q, terr_d;
`endif

  logic [DATA_W-1:0]  core_data [CORES];
  logic [IDW-1:0]     rr_idx;
  logic               rr_found;

  always_comb begin
    for (int unsigned i = 0; i < CORES; i++) begin
      core_data[i] = core_src_q[i*DATA_W +: DATA_W];
    end
  end

  // First pending core strictly after last_grant; CORES is a power of two so truncation wraps.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int unsigned off = 1; off <= CORES; off++) begin
      if (!rr_found && pending_q[IDW'(32'(last_grant_q) + off)]) begin
        rr_idx   = IDW'(32'(last_grant_q) + off);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    halt_d_d     = core_halt;
    pending_set  = core_halt & ~halt_d_q;
    pending_clr  = '0;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    req_d        = '0;
    data_d       = '0;
    valid_d      = 1'b0;
    sop_d        = 1'b0;
    eop_d        = 1'b0;
    release_d    = 1'b0;
    rel_id_d     = '0;
    packets_d    = packets_q;
    pkt_done     = 1'b0;
`ifdef MSPU_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    terr_d       = terr_q;
`endif
    case (state_q)
      IDLE: begin
        if (pending_q != '0 && src_ready) begin
          grant_d             = rr_idx;
          last_grant_d        = rr_idx;
          pending_clr[rr_idx] = 1'b1;
          req_d[rr_idx]       = 1'b1;
          state_d             = REQ;
        end
      end
      REQ: begin
        state_d = STREAM;
`ifdef MSPU_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      STREAM: begin
        data_d   = core_data[grant_q];
        valid_d  = core_src_valid[grant_q];
        sop_d    = core_src_valid[grant_q] & core_src_sop[grant_q];
        eop_d    = core_src_valid[grant_q] & core_src_eop[grant_q];
        pkt_done = eop_d;
`ifdef MSPU_ARB_TIMEOUT_EN
        cnt_d    = cnt_q + 32'd1;
        // Real eop takes priority over the watchdog firing on the same cycle.
        if (!eop_d && cnt_q == TIMEOUT - 1) begin
          data_d   = '0;
          valid_d  = 1'b1;
          sop_d    = 1'b0;
          eop_d    = 1'b1;
          terr_d   = 1'b1;
          pkt_done = 1'b1;
        end
`endif
        if (pkt_done) begin
          state_d   = RELEASE;
          release_d = 1'b1;
          rel_id_d  = grant_q;
          packets_d = packets_q + 32'd1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q | pending_set) & ~pending_clr;
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      halt_d_q     <= '0;
      pending_q    <= '0;
      grant_q      <= '0;
      last_grant_q <= IDW'(CORES - 1);
      req_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      release_q    <= 1'b0;
      rel_id_q     <= '0;
      busy_q       <= 1'b0;
      packets_q    <= '0;
`ifdef MSPU_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      terr_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      halt_d_q     <= halt_d_d;
      pending_q    <= pending_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      req_q        <= req_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      release_q    <= release_d;
      rel_id_q     <= rel_id_d;
      busy_q       <= busy_d;
      packets_q    <= packets_d;
`ifdef MSPU_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
      terr_q       <= terr_d;
`endif
    end
  end

  assign core_src_req     = req_q;
  assign src_data         = data_q;
  assign src_valid        = valid_q;
  assign src_sop          = sop_q;
  assign src_eop          = eop_q;
  assign core_release     = release_q;
  assign released_core_id = rel_id_q;
  assign busy             = busy_q;
  assign packets_sent     = packets_q;
`ifdef MSPU_ARB_TIMEOUT_EN
  assign timeout_err      = terr_q;
`endif

endmodule
